// File: rtl/runway_arbiter.sv
// runway_arbiter: single-runway landing/takeoff arbiter with round-robin grants,
// occupancy timeout into a fault lockout, and weather-driven takeoff inhibit.
module runway_arbiter #(
  parameter int OCC_LIMIT    = 16,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] ECSU_state,
  input  logic       emergency_landing_alert,
  input  logic [3:0] land_req,
  input  logic [3:0] takeoff_req,
  input  logic       op_done,
  output logic [3:0] land_grant,
  output logic [3:0] takeoff_grant,
  output logic [1:0] runway_state,
  output logic       runway_fault,
  output logic       takeoff_inhibit
);
  typedef enum logic [1:0] {IDLE, LANDING, TAKEOFF, FAULT} state_e;
  state_e     state_q = IDLE, state_d;
  logic [3:0] land_grant_q = '0, land_grant_d;
  logic [3:0] takeoff_grant_q = '0, takeoff_grant_d;
  logic       fault_q = 1'b0, fault_d;
  logic [1:0] lptr_q = '0, lptr_d, tptr_q = '0, tptr_d;
  logic [4:0] occ_q = '0, occ_d, lock_q = '0, lock_d;
  logic [3:0] t_req;
  logic       l_any, t_any, busy, idle, occ_timeout, lock_done;
  logic [1:0] l_idx, t_idx;
  assign takeoff_inhibit = ECSU_state[1] | emergency_landing_alert;
  assign t_req           = takeoff_req & {4{~takeoff_inhibit}};
  assign idle            = state_q == IDLE;
  assign busy            = state_q == LANDING || state_q == TAKEOFF;
  assign occ_timeout     = occ_q == 5'(OCC_LIMIT - 1);
  assign lock_done       = lock_q == 5'(CLEAR_CYCLES - 1);
  // Scan offsets high to low so the request nearest the pointer wins.
  always_comb begin
    l_any = 1'b0;
    l_idx = lptr_q;
    t_any = 1'b0;
    t_idx = tptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (land_req[lptr_q + 2'(k)]) begin
        l_any = 1'b1;
        l_idx = lptr_q + 2'(k);
      end
      if (t_req[tptr_q + 2'(k)]) begin
        t_any = 1'b1;
        t_idx = tptr_q + 2'(k);
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= IDLE;
      land_grant_q    <= '0;
      takeoff_grant_q <= '0;
      fault_q         <= 1'b0;
      lptr_q          <= '0;
      tptr_q          <= '0;
      occ_q           <= '0;
      lock_q          <= '0;
    end else begin
      state_q         <= state_d;
      land_grant_q    <= land_grant_d;
      takeoff_grant_q <= takeoff_grant_d;
      fault_q         <= fault_d;
      lptr_q          <= lptr_d;
      tptr_q          <= tptr_d;
      occ_q           <= occ_d;
      lock_q          <= lock_d;
    end
  end
  // op_done is checked before the timeout so it wins when both coincide.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = l_any ? LANDING : t_any ? TAKEOFF : IDLE;
      FAULT:   state_d = lock_done ? IDLE : FAULT;
      default: state_d = op_done ? IDLE : occ_timeout ? FAULT : state_q;
    endcase
  end
  always_comb begin
    land_grant_d    = state_d == LANDING ? (idle ? 4'b0001 << l_idx : land_grant_q) : 4'b0000;
    takeoff_grant_d = state_d == TAKEOFF ? (idle ? 4'b0001 << t_idx : takeoff_grant_q) : 4'b0000;
    fault_d         = state_d == FAULT;
    lptr_d          = idle && l_any ? l_idx + 2'd1 : lptr_q;
    tptr_d          = idle && !l_any && t_any ? t_idx + 2'd1 : tptr_q;
    occ_d           = busy ? occ_q + 5'd1 : 5'd0;
    lock_d          = state_q == FAULT ? lock_q + 5'd1 : 5'd0;
  end
  assign land_grant    = land_grant_q;
  assign takeoff_grant = takeoff_grant_q;
  assign runway_state  = state_q;
  assign runway_fault  = fault_q;
endmodule

// File: tb/tb_runway_arbiter.sv
// tb_runway_arbiter: directed-step bench for runway_arbiter at default parameters.
module tb_runway_arbiter;
  logic       CLK = 1'b0, RST = 1'b1;
  logic [1:0] ECSU_state = 2'b00;
  logic       emergency_landing_alert = 1'b0;
  logic [3:0] land_req = '0, takeoff_req = '0;
  logic       op_done = 1'b0;
  logic [3:0] land_grant, takeoff_grant;
  logic [1:0] runway_state;
  logic       runway_fault, takeoff_inhibit;
  int n_cmp = 0, n_err = 0;
  runway_arbiter dut (
    .CLK(CLK), .RST(RST), .ECSU_state(ECSU_state),
    .emergency_landing_alert(emergency_landing_alert),
    .land_req(land_req), .takeoff_req(takeoff_req), .op_done(op_done),
    .land_grant(land_grant), .takeoff_grant(takeoff_grant),
    .runway_state(runway_state), .runway_fault(runway_fault),
    .takeoff_inhibit(takeoff_inhibit)
  );
  always #5 CLK = ~CLK;
  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [1:0] st, input logic [3:0] lg,
                         input logic [3:0] tg, input logic flt);
    chk({tag, ".state"}, {6'd0, runway_state}, {6'd0, st});
    chk({tag, ".land"}, {4'd0, land_grant}, {4'd0, lg});
    chk({tag, ".takeoff"}, {4'd0, takeoff_grant}, {4'd0, tg});
    chk({tag, ".fault"}, {7'd0, runway_fault}, {7'd0, flt});
  endtask
  initial begin
    tick(2);
    chk_all("reset", 2'b00, 4'b0000, 4'b0000, 1'b0);
    RST = 1'b0;
    // Landing beats takeoff, then takeoff follows once the runway clears.
    land_req = 4'b0001; takeoff_req = 4'b0010;
    tick();
    chk_all("land_first", 2'b01, 4'b0001, 4'b0000, 1'b0);
    land_req = 4'b0000; op_done = 1'b1;
    tick();
    chk_all("land_done", 2'b00, 4'b0000, 4'b0000, 1'b0);
    op_done = 1'b0;
    tick();
    chk_all("takeoff_next", 2'b10, 4'b0000, 4'b0010, 1'b0);
    takeoff_req = 4'b0000; op_done = 1'b1;
    tick();
    op_done = 1'b0;
    chk_all("takeoff_done", 2'b00, 4'b0000, 4'b0000, 1'b0);
    // Landing round-robin from a fresh reset.
    RST = 1'b1;
    tick();
    RST = 1'b0; land_req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_grant%0d", i), {4'd0, land_grant}, {4'd0, 4'b0001 << (i % 4)});
      tick();
      chk($sformatf("rr_hold%0d", i), {4'd0, land_grant}, {4'd0, 4'b0001 << (i % 4)});
      op_done = 1'b1;
      tick();
      op_done = 1'b0;
      chk($sformatf("rr_idle%0d", i), {6'd0, runway_state}, 8'd0);
      tick();
    end
    chk("rr_wrap", {4'd0, land_grant}, 8'h02);
    land_req = 4'b0000; op_done = 1'b1;
    tick();
    op_done = 1'b0;
    // Weather inhibit blocks takeoff without queueing it.
    RST = 1'b1;
    tick();
    RST = 1'b0; takeoff_req = 4'b0001; ECSU_state = 2'b10;
    #1 chk("inhibit_ecsu", {7'd0, takeoff_inhibit}, 8'd1);
    tick();
    chk_all("inhibit_hold", 2'b00, 4'b0000, 4'b0000, 1'b0);
    ECSU_state = 2'b00; emergency_landing_alert = 1'b1;
    #1 chk("inhibit_alert", {7'd0, takeoff_inhibit}, 8'd1);
    tick();
    chk_all("alert_hold", 2'b00, 4'b0000, 4'b0000, 1'b0);
    emergency_landing_alert = 1'b0; ECSU_state = 2'b01;
    #1 chk("caution_ok", {7'd0, takeoff_inhibit}, 8'd0);
    tick();
    chk_all("caution_grant", 2'b10, 4'b0000, 4'b0001, 1'b0);
    ECSU_state = 2'b11; takeoff_req = 4'b0000;
    tick();
    chk_all("grant_held", 2'b10, 4'b0000, 4'b0001, 1'b0);
    op_done = 1'b1;
    tick();
    op_done = 1'b0; ECSU_state = 2'b00;
    // Occupancy timeout into fault lockout; requests ignored in FAULT.
    land_req = 4'b0100;
    tick();
    chk_all("occ_start", 2'b01, 4'b0100, 4'b0000, 1'b0);
    land_req = 4'b1111;
    tick(15);
    chk_all("occ_16th", 2'b01, 4'b0100, 4'b0000, 1'b0);
    tick();
    chk_all("fault_enter", 2'b11, 4'b0000, 4'b0000, 1'b1);
    op_done = 1'b1;
    tick(3);
    op_done = 1'b0;
    chk_all("fault_4th", 2'b11, 4'b0000, 4'b0000, 1'b1);
    tick();
    chk_all("fault_exit", 2'b00, 4'b0000, 4'b0000, 1'b0);
    tick();
    chk_all("post_fault", 2'b01, 4'b1000, 4'b0000, 1'b0);
    // op_done on the last occupancy cycle wins over the timeout.
    tick(15);
    chk_all("edge_16th", 2'b01, 4'b1000, 4'b0000, 1'b0);
    op_done = 1'b1; land_req = 4'b0000;
    tick();
    op_done = 1'b0;
    chk_all("done_wins", 2'b00, 4'b0000, 4'b0000, 1'b0);
    // Reset during TAKEOFF restarts the round-robin.
    takeoff_req = 4'b0010;
    tick();
    chk_all("to_grant", 2'b10, 4'b0000, 4'b0010, 1'b0);
    RST = 1'b1;
    tick();
    chk_all("rst_mid", 2'b00, 4'b0000, 4'b0000, 1'b0);
    RST = 1'b0; takeoff_req = 4'b1111;
    tick();
    chk_all("rr_restart", 2'b10, 4'b0000, 4'b0001, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/runway_arbiter.md
RUNWAY_ARBITER -- requirements
Module: runway_arbiter

Interface
REQ-001 The block SHALL have parameter OCC_LIMIT, default 16, setting the maximum runway occupancy in cycles per grant (range 2..31).
REQ-002 The block SHALL have parameter CLEAR_CYCLES, default 4, setting the fault lockout duration in cycles (range 1..31).
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 ECSU_state  input  2  weather state: 00 ALL_CLEAR, 01 CAUTION, 10 HIGH_ALERT, 11 EMERGENCY.
REQ-006 emergency_landing_alert  input  1  emergency landing alert from the weather unit.
REQ-007 land_req  input  4  per-aircraft landing request, level-sensitive.
REQ-008 takeoff_req  input  4  per-aircraft takeoff request, level-sensitive.
REQ-009 op_done  input  1  the current runway user reports the runway clear, one-cycle pulse.
REQ-010 land_grant  output  4  registered, one-hot or zero landing grant.
REQ-011 takeoff_grant  output  4  registered, one-hot or zero takeoff grant.
REQ-012 runway_state  output  2  registered FSM state: 00 IDLE, 01 LANDING, 10 TAKEOFF, 11 FAULT.
REQ-013 runway_fault  output  1  registered; high exactly while in FAULT.
REQ-014 takeoff_inhibit  output  1  combinational; equals (ECSU_state[1] OR emergency_landing_alert).

Function
REQ-015 At most one bit across land_grant and takeoff_grant together SHALL be high in any cycle.
REQ-016 Arbitration SHALL occur only in IDLE, on each rising edge, using the request values sampled at that edge.
REQ-017 Arbitration priority: any land_req bit beats all takeoff_req bits, in every ECSU_state.
REQ-018 Takeoff arbitration SHALL consider takeoff_req only when takeoff_inhibit is 0; when it is 1, takeoff requests are ignored (not queued).
REQ-019 Landing and takeoff SHALL each use an independent 2-bit round-robin pointer; the search starts at the pointer index and proceeds upward mod 4.
REQ-020 On a grant to index i, the matching pointer SHALL become (i+1) mod 4; the other pointer is unchanged.
REQ-021 IDLE with a winner at edge N: the grant bit and runway_state (LANDING or TAKEOFF) SHALL be visible from edge N; occupancy counter occ_cnt SHALL be cleared to 0.
REQ-022 In LANDING/TAKEOFF, the grant SHALL stay held regardless of request deassertion or ECSU_state changes; only op_done or a timeout releases it.
REQ-023 op_done high at an edge in LANDING/TAKEOFF: next state IDLE, grants 0; the earliest new grant is at the following edge.
REQ-024 In LANDING/TAKEOFF without op_done, occ_cnt SHALL increment each edge; if occ_cnt==OCC_LIMIT-1 at an edge: next state FAULT, grants 0, runway_fault 1, lockout counter cleared to 0.
REQ-025 When op_done and the timeout condition coincide, op_done SHALL win (go to IDLE, no fault).
REQ-026 In FAULT, requests and op_done SHALL be ignored; the lockout counter increments each edge; at count CLEAR_CYCLES-1 next state IDLE, runway_fault 0.
REQ-027 op_done in IDLE or FAULT SHALL have no effect.
REQ-028 Consequence: a grant lasts 1..OCC_LIMIT cycles; FAULT lasts exactly CLEAR_CYCLES cycles.

Reset
REQ-029 RST high at an edge SHALL force: runway_state 00, land_grant 0, takeoff_grant 0, runway_fault 0, both pointers 0, both counters 0; this takes priority over all other inputs.
REQ-030 RST asserted mid-operation (LANDING/TAKEOFF/FAULT) SHALL drop the grant at that edge with no fault indication.
REQ-031 An initial block SHALL establish the same values as reset for simulation start.

Verification
REQ-032 land_req=0001, takeoff_req=0010, ECSU_state=00 -> land_grant=0001, runway_state=01 after one edge; op_done pulse -> IDLE; next edge takeoff_grant=0010.
REQ-033 land_req=1111 held, op_done every 3rd cycle -> land_grant sequence 0001,0010,0100,1000,0001.
REQ-034 takeoff_req=0001, ECSU_state=10 (or alert=1) -> takeoff_inhibit=1, no grant, state stays 00; ECSU_state->01 -> takeoff_grant=0001 next edge.
REQ-035 Grant with no op_done, defaults -> grant high 16 cycles, then runway_fault=1, state 11 for 4 cycles, then IDLE; requests during FAULT not granted.
REQ-036 op_done coinciding with the 16th occupancy cycle -> IDLE, runway_fault stays 0.
REQ-037 RST during TAKEOFF -> all outputs zero at that edge; round-robin restarts from index 0.
